// File: rtl/search_drive.sv
// search_drive: serpentine search-pattern H-bridge driver.
// Sweeps forward, stop, pivot, stop with the pivot direction alternating
// each leg. Every direction change passes through a timed all-off stop.
// Optional soft start on forward legs is enabled by defining SEARCH_RAMP_EN.
module search_drive #(
  parameter int PRESCALE   = 4,
  parameter int FWD_TICKS  = 10,
  parameter int TURN_TICKS = 3,
  parameter int STOP_TICKS = 2,
  parameter int RAMP_STEP  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable_search,
  input  logic [7:0] duty,
  output logic [3:0] motor_in,
  output logic       pwm_en,
  output logic       search_busy,
  output logic [7:0] leg_count
);

  typedef enum logic [2:0] {
    StIdle,
    StForward,
    StStopF,
    StTurn,
    StStopT,
    StHalt
  } state_e;

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PreMax  = PW'(PRESCALE - 1);
  localparam logic [15:0]   FwdMax  = 16'(FWD_TICKS - 1);
  localparam logic [15:0]   TurnMax = 16'(TURN_TICKS - 1);
  localparam logic [15:0]   StopMax = 16'(STOP_TICKS - 1);

  localparam logic [3:0] CodeFwd   = 4'b1010;
  localparam logic [3:0] CodeLeft  = 4'b0110;
  localparam logic [3:0] CodeRight = 4'b1001;
  localparam logic [3:0] CodeOff   = 4'b0000;

  state_e        state_q, state_d;
  logic          en_q;
  logic [PW-1:0] pre_q, pre_d;
  logic [15:0]   tick_q, tick_d;
  logic          abort_q, abort_d;
  logic          turn_left_q, turn_left_d;
  logic [7:0]    leg_q, leg_d;
  logic [7:0]    pc_q, pc_d;
  logic [7:0]    cur_duty_q, cur_duty_d;
  logic [3:0]    motor_q, motor_d;
  logic          pwm_q, pwm_d;
  logic          busy_q, busy_d;

  logic          lastTick;
  logic          expire;
  logic          stateChange;
  logic          enterFwd;
  logic          enterTurn;
  logic [15:0]   tickMax;

`ifdef SEARCH_RAMP_EN
  logic [7:0]    target_q, target_d;
  logic [8:0]    rampSum;
`endif

  // Next-state, timing, counters and the registered-output values, all
  // derived from the state being entered so outputs line up with the state.
  always_comb begin
    state_d     = state_q;
    abort_d     = abort_q;
    turn_left_d = turn_left_q;
    leg_d       = leg_q;
    cur_duty_d  = cur_duty_q;
    pre_d       = pre_q;
    tick_d      = tick_q;
    motor_d     = CodeOff;
`ifdef SEARCH_RAMP_EN
    target_d    = target_q;
    rampSum     = {1'b0, cur_duty_q} + 9'(RAMP_STEP);
`endif

    lastTick = (pre_q == PreMax);
    tickMax  = StopMax;
    case (state_q)
      StForward: tickMax = FwdMax;
      StTurn:    tickMax = TurnMax;
      default:   tickMax = StopMax;
    endcase
    expire = lastTick && (tick_q == tickMax);

    case (state_q)
      StIdle: begin
        if (en_q) begin
          state_d     = StForward;
          leg_d       = 8'd0;
          turn_left_d = 1'b1;
        end
      end
      StForward: begin
        if (!en_q) begin
          state_d = StHalt;
        end else if (expire) begin
          state_d = StStopF;
        end
      end
      StStopF: begin
        if (expire) begin
          state_d = (abort_q || !en_q) ? StIdle : StTurn;
        end
      end
      StTurn: begin
        if (!en_q) begin
          state_d = StHalt;
        end else if (expire) begin
          state_d     = StStopT;
          leg_d       = leg_q + 8'd1;
          turn_left_d = !turn_left_q;
        end
      end
      StStopT: begin
        if (expire) begin
          state_d = (abort_q || !en_q) ? StIdle : StForward;
        end
      end
      StHalt: begin
        if (expire) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    stateChange = (state_d != state_q);
    enterFwd    = stateChange && (state_d == StForward);
    enterTurn   = stateChange && (state_d == StTurn);

    if (stateChange || (state_q == StIdle)) begin
      pre_d  = '0;
      tick_d = 16'd0;
    end else if (lastTick) begin
      pre_d  = '0;
      tick_d = tick_q + 16'd1;
    end else begin
      pre_d  = pre_q + PW'(1);
    end

    if (stateChange) begin
      abort_d = 1'b0;
    end else if (((state_q == StStopF) || (state_q == StStopT)) && !en_q) begin
      abort_d = 1'b1;
    end

`ifdef SEARCH_RAMP_EN
    if (enterFwd) begin
      cur_duty_d = 8'd0;
      target_d   = duty;
    end else if (enterTurn) begin
      cur_duty_d = duty;
    end else if ((state_q == StForward) && (state_d == StForward) && lastTick) begin
      cur_duty_d = (rampSum >= {1'b0, target_q}) ? target_q : rampSum[7:0];
    end
`else
    if (enterFwd || enterTurn) begin
      cur_duty_d = duty;
    end
`endif

    pc_d = pc_q + 8'd1;

    case (state_d)
      StForward: motor_d = CodeFwd;
      StTurn:    motor_d = turn_left_d ? CodeLeft : CodeRight;
      default:   motor_d = CodeOff;
    endcase

    busy_d = (state_d != StIdle);
    pwm_d  = ((state_d == StForward) || (state_d == StTurn)) && (pc_d < cur_duty_d);
  end

  // State register with registered outputs; reset drops the bridge immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      en_q        <= 1'b0;
      pre_q       <= '0;
      tick_q      <= 16'd0;
      abort_q     <= 1'b0;
      turn_left_q <= 1'b1;
      leg_q       <= 8'd0;
      pc_q        <= 8'd0;
      cur_duty_q  <= 8'd0;
      motor_q     <= CodeOff;
      pwm_q       <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SEARCH_RAMP_EN
      target_q    <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      en_q        <= enable_search;
      pre_q       <= pre_d;
      tick_q      <= tick_d;
      abort_q     <= abort_d;
      turn_left_q <= turn_left_d;
      leg_q       <= leg_d;
      pc_q        <= pc_d;
      cur_duty_q  <= cur_duty_d;
      motor_q     <= motor_d;
      pwm_q       <= pwm_d;
      busy_q      <= busy_d;
`ifdef SEARCH_RAMP_EN
      target_q    <= target_d;
`endif
    end
  end

  assign motor_in    = motor_q;
  assign pwm_en      = pwm_q;
  assign search_busy = busy_q;
  assign leg_count   = leg_q;

endmodule

// File: tb/tb_search_drive.sv
// tb_search_drive: checks search_drive against a cycle-count reference model.
// The model tracks each state as a block of N*PRESCALE cycles and derives the
// PWM from a free-running cycle count; SEARCH_RAMP_EN is honoured if defined.
module tb_search_drive;

  localparam int P  = 4;
  localparam int FT = 10;
  localparam int TT = 3;
  localparam int ST = 2;
  localparam int RS = 16;

  localparam int M_IDLE  = 0;
  localparam int M_FWD   = 1;
  localparam int M_STOPF = 2;
  localparam int M_TURN  = 3;
  localparam int M_STOPT = 4;
  localparam int M_HALT  = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable_search = 1'b0;
  logic [7:0] duty = 8'd0;
  logic [3:0] motor_in;
  logic       pwm_en;
  logic       search_busy;
  logic [7:0] leg_count;

  int passCount = 0;
  int totalCount = 0;
  int failCount = 0;

  int mState, mRemain, mElapsed, mLeg, mDuty, mPc;
  bit mLeft, mEnQ, mAbort;

  logic [3:0] prevMotor = 4'd0;
  bit         recOn = 0;
  bit         recStarted = 0;
  logic [3:0] runCode[$];
  int         runLen[$];

  // Free-running system clock.
  always #5 clk = ~clk;

  search_drive #(
    .PRESCALE(P), .FWD_TICKS(FT), .TURN_TICKS(TT), .STOP_TICKS(ST), .RAMP_STEP(RS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable_search(enable_search),
    .duty(duty),
    .motor_in(motor_in),
    .pwm_en(pwm_en),
    .search_busy(search_busy),
    .leg_count(leg_count)
  );

  task automatic doCheck(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCount++;
    assert (obs === exp) begin
      passCount++;
    end else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int stateCycles(input int s);
    case (s)
      M_FWD:   return FT * P;
      M_TURN:  return TT * P;
      M_IDLE:  return 0;
      default: return ST * P;
    endcase
  endfunction

  function automatic int expMotor();
    if (mState == M_FWD) return 4'b1010;
    if (mState == M_TURN) return mLeft ? 4'b0110 : 4'b1001;
    return 0;
  endfunction

  function automatic int expDutyNow();
`ifdef SEARCH_RAMP_EN
    if (mState == M_FWD) begin
      int r;
      r = RS * (mElapsed / P);
      return (r < mDuty) ? r : mDuty;
    end
`endif
    return mDuty;
  endfunction

  function automatic int expPwm();
    if ((mState == M_FWD) || (mState == M_TURN)) return (mPc < expDutyNow()) ? 1 : 0;
    return 0;
  endfunction

  task automatic modelReset();
    mState = M_IDLE; mRemain = 0; mElapsed = 0; mLeg = 0; mDuty = 0; mPc = 0;
    mLeft = 1; mEnQ = 0; mAbort = 0;
    prevMotor = 4'd0;
  endtask

  task automatic modelEdge();
    int nxt;
    bit expire, en;
    nxt = mState;
    expire = (mRemain == 1);
    en = mEnQ;
    case (mState)
      M_IDLE:  if (en) begin nxt = M_FWD; mLeg = 0; mLeft = 1; end
      M_FWD:   if (!en) nxt = M_HALT; else if (expire) nxt = M_STOPF;
      M_STOPF: if (expire) nxt = (mAbort || !en) ? M_IDLE : M_TURN;
      M_TURN:  if (!en) nxt = M_HALT;
               else if (expire) begin nxt = M_STOPT; mLeg = (mLeg + 1) % 256; mLeft = !mLeft; end
      M_STOPT: if (expire) nxt = (mAbort || !en) ? M_IDLE : M_FWD;
      M_HALT:  if (expire) nxt = M_IDLE;
      default: nxt = M_IDLE;
    endcase
    if (((mState == M_STOPF) || (mState == M_STOPT)) && !en) mAbort = 1;
    if (nxt != mState) begin
      mState = nxt; mElapsed = 0; mAbort = 0; mRemain = stateCycles(nxt);
      if ((nxt == M_FWD) || (nxt == M_TURN)) mDuty = duty;
    end else if (mState != M_IDLE) begin
      mRemain--; mElapsed++;
    end
    mPc = (mPc + 1) % 256;
    mEnQ = enable_search;
  endtask

  task automatic checkOutput();
    doCheck("motor_in", motor_in, expMotor());
    doCheck("search_busy", search_busy, (mState != M_IDLE) ? 1 : 0);
    doCheck("leg_count", leg_count, mLeg);
    doCheck("pwm_en", pwm_en, expPwm());
    if ((prevMotor != 4'd0) && (motor_in != 4'd0))
      doCheck("no_direct_change", motor_in, prevMotor);
    prevMotor = motor_in;
    if (recOn) begin
      if (!recStarted && (motor_in != 4'd0)) recStarted = 1;
      if (recStarted) begin
        if ((runCode.size() == 0) || (runCode[runCode.size()-1] != motor_in)) begin
          runCode.push_back(motor_in);
          runLen.push_back(1);
        end else begin
          runLen[runLen.size()-1]++;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [7:0] d);
    enable_search = en;
    duty = d;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    if (rst_n) modelEdge();
    #1;
    checkOutput();
  endtask

  task automatic applyReset();
    #2 rst_n = 1'b0;
    #1 modelReset();
    checkOutput();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    while ((mState != M_IDLE) && (n < 200)) begin stepCycle(); n++; end
    doCheck(tag, (n < 200) ? 1 : 0, 1);
  endtask

  // Directed and randomized stimulus in one linear sequence.
  initial begin
    int expCode[7];
    int expLen[7];
    int n, cnt, pwmHigh;

    modelReset();
    #1 checkOutput();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    $display("[TB] idle after reset");
    repeat (100) stepCycle();

    $display("[TB] sweep sequence");
    recOn = 1;
    applyStimulus(1'b1, 8'd128);
    repeat (140) stepCycle();
    recOn = 0;
    expCode = '{4'b1010, 4'b0000, 4'b0110, 4'b0000, 4'b1010, 4'b0000, 4'b1001};
    expLen  = '{FT*P, ST*P, TT*P, ST*P, FT*P, ST*P, TT*P};
    doCheck("sweep_run_count", (runCode.size() >= 7) ? 1 : 0, 1);
    for (int i = 0; i < 7; i++) begin
      if (i < runCode.size()) begin
        doCheck($sformatf("sweep_code_%0d", i), runCode[i], expCode[i]);
        doCheck($sformatf("sweep_len_%0d", i), runLen[i], expLen[i]);
      end
    end

    $display("[TB] disable mid-leg");
    n = 0;
    while (!((mState == M_FWD) && (mElapsed == 15)) && (n < 300)) begin stepCycle(); n++; end
    doCheck("reach_fwd_cycle15", (n < 300) ? 1 : 0, 1);
    applyStimulus(1'b0, 8'd128);
    cnt = 0; n = 0;
    stepCycle();
    while (search_busy && (n < 50)) begin
      if (motor_in == 4'd0) cnt++;
      stepCycle(); n++;
    end
    doCheck("halt_cycles", cnt, ST * P);
    doCheck("idle_after_halt", search_busy, 0);

    $display("[TB] disable on last forward cycle, re-enable in halt");
    applyStimulus(1'b1, 8'd200);
    n = 0;
    while (!((mLeg >= 1) && (mState == M_FWD) && (mRemain == 2)) && (n < 400)) begin
      stepCycle(); n++;
    end
    doCheck("reach_last_fwd", (n < 400) ? 1 : 0, 1);
    applyStimulus(1'b0, 8'd200);
    repeat (4) stepCycle();
    applyStimulus(1'b1, 8'd200);
    n = 0;
    while ((motor_in == 4'd0) && (n < 50)) begin stepCycle(); n++; end
    doCheck("restart_code", motor_in, 4'b1010);
    doCheck("restart_leg_cleared", leg_count, 0);
    n = 0;
    while (((motor_in == 4'd0) || (motor_in == 4'b1010)) && (n < 100)) begin stepCycle(); n++; end
    doCheck("first_turn_left", motor_in, 4'b0110);
    applyStimulus(1'b0, 8'd200);
    waitIdle("idle_after_restart");

    $display("[TB] duty zero");
    applyStimulus(1'b1, 8'd0);
    pwmHigh = 0;
    for (int i = 0; i < 150; i++) begin
      stepCycle();
      if (pwm_en) pwmHigh++;
    end
    doCheck("duty0_pwm_high", pwmHigh, 0);
    applyStimulus(1'b0, 8'd0);
    waitIdle("idle_after_duty0");

    $display("[TB] randomized runs");
    for (int r = 0; r < 8; r++) begin
      applyStimulus(1'b1, (r == 0) ? 8'd64 : 8'($urandom_range(0, 255)));
      n = $urandom_range(10, 220);
      for (int i = 0; i < n; i++) begin
        if (r[0]) duty = 8'($urandom_range(0, 255));
        stepCycle();
        if ((r == 4) && (i == n / 2)) begin
          applyReset();
          stepCycle();
        end
      end
      applyStimulus(1'b0, duty);
      repeat ($urandom_range(1, 6)) stepCycle();
      if (r[1]) applyStimulus(1'b1, duty);
      repeat ($urandom_range(1, 12)) stepCycle();
      applyStimulus(1'b0, duty);
      waitIdle($sformatf("idle_round_%0d", r));
      repeat (3) stepCycle();
    end

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
